// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write arbiter slice.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;
  localparam int CNT_W    = 16;

  typedef logic [ADDR_W-1:0]   reg_addr_t;
  typedef logic [DATA_W-1:0]   reg_data_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

  function automatic reg_mask_t addr_onehot(input reg_addr_t addr);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback / scoreboard bundle between the pipeline and the write arbiter.
// Bypass signals exist only when REGFILE_ARB_BYPASS_EN is defined.
interface regfile_write_arbiter_if;
  import regfile_pkg::*;

  logic      req0_valid, req0_ready, req1_valid, req1_ready;
  reg_addr_t req0_addr, req1_addr;
  reg_data_t req0_data, req1_data;
  logic      rsv_valid, rsv_ready;
  reg_addr_t rsv_addr;
  reg_addr_t rd_addr1, rd_addr2;
  logic      rd_stall;
  logic      rf_we;
  reg_addr_t rf_waddr;
  reg_data_t rf_wdata;
  reg_mask_t pending;
  cnt_t      conflict_cnt;
`ifdef REGFILE_ARB_BYPASS_EN
  logic      byp_hit1, byp_hit2;
  reg_data_t byp_data;

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  rsv_valid, rsv_addr, rd_addr1, rd_addr2,
    output req0_ready, req1_ready, rsv_ready, rd_stall,
    output rf_we, rf_waddr, rf_wdata, pending, conflict_cnt,
    output byp_hit1, byp_hit2, byp_data
  );
  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output rsv_valid, rsv_addr, rd_addr1, rd_addr2,
    input  req0_ready, req1_ready, rsv_ready, rd_stall,
    input  rf_we, rf_waddr, rf_wdata, pending, conflict_cnt,
    input  byp_hit1, byp_hit2, byp_data
  );
`else
  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  rsv_valid, rsv_addr, rd_addr1, rd_addr2,
    output req0_ready, req1_ready, rsv_ready, rd_stall,
    output rf_we, rf_waddr, rf_wdata, pending, conflict_cnt
  );
  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output rsv_valid, rsv_addr, rd_addr1, rd_addr2,
    input  req0_ready, req1_ready, rsv_ready, rd_stall,
    input  rf_we, rf_waddr, rf_wdata, pending, conflict_cnt
  );
`endif
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; rr_last only moves on contended cycles.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  output logic gnt0,
  output logic gnt1
);

  logic rr_last_r;

  // Contended cycles favour the port that did not win last time.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (valid0 && valid1) begin
      gnt0 = rr_last_r;
      gnt1 = ~rr_last_r;
    end else begin
      gnt0 = valid0;
      gnt1 = valid1;
    end
  end

  // Remember the winner of the most recent conflict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last_r <= 1'b1;
    end else if (valid0 && valid1) begin
      rr_last_r <= gnt1;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load unit and keeps a
// pending scoreboard. Optional REGFILE_ARB_BYPASS_EN adds write-port bypass.
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_write_arbiter_if.slave  bus
);

  logic      gnt0_s, gnt1_s, conflict_s, rsv_fire_s;
  reg_mask_t pending_next_s, stall_mask_s;
  logic      rf_we_r;
  reg_addr_t rf_waddr_r;
  reg_data_t rf_wdata_r;
  reg_mask_t pending_r;
  cnt_t      conflict_cnt_r;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .gnt0   (gnt0_s),
    .gnt1   (gnt1_s)
  );

  assign conflict_s     = bus.req0_valid & bus.req1_valid;
  assign rsv_fire_s     = bus.rsv_valid & ~pending_r[bus.rsv_addr];
  assign bus.req0_ready = gnt0_s;
  assign bus.req1_ready = gnt1_s;
  assign bus.rsv_ready  = ~pending_r[bus.rsv_addr];

  // Clear on commit first, then set, so a same-edge reservation survives.
  always_comb begin
    pending_next_s = pending_r;
    if (rf_we_r) begin
      pending_next_s = pending_next_s & ~addr_onehot(rf_waddr_r);
    end else begin
      pending_next_s = pending_next_s;
    end
    if (rsv_fire_s) begin
      pending_next_s = pending_next_s | addr_onehot(bus.rsv_addr);
    end else begin
      pending_next_s = pending_next_s;
    end
  end

  // Pending bits that still block readers this cycle.
  always_comb begin
    stall_mask_s = pending_r;
`ifdef REGFILE_ARB_BYPASS_EN
    if (rf_we_r) begin
      stall_mask_s = pending_r & ~addr_onehot(rf_waddr_r);
    end else begin
      stall_mask_s = pending_r;
    end
`endif
  end

  assign bus.rd_stall = stall_mask_s[bus.rd_addr1] | stall_mask_s[bus.rd_addr2];

`ifdef REGFILE_ARB_BYPASS_EN
  assign bus.byp_hit1 = rf_we_r && (rf_waddr_r == bus.rd_addr1);
  assign bus.byp_hit2 = rf_we_r && (rf_waddr_r == bus.rd_addr2);
  assign bus.byp_data = rf_wdata_r;
`endif

  // Write-port registers, scoreboard and saturating conflict counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_r        <= 1'b0;
      rf_waddr_r     <= {ADDR_W{1'b0}};
      rf_wdata_r     <= {DATA_W{1'b0}};
      pending_r      <= {NUM_REGS{1'b0}};
      conflict_cnt_r <= {CNT_W{1'b0}};
    end else begin
      rf_we_r   <= gnt0_s | gnt1_s;
      pending_r <= pending_next_s;
      if (gnt0_s) begin
        rf_waddr_r <= bus.req0_addr;
        rf_wdata_r <= bus.req0_data;
      end else if (gnt1_s) begin
        rf_waddr_r <= bus.req1_addr;
        rf_wdata_r <= bus.req1_data;
      end else begin
        rf_waddr_r <= rf_waddr_r;
        rf_wdata_r <= rf_wdata_r;
      end
      if (conflict_s && (conflict_cnt_r != {CNT_W{1'b1}})) begin
        conflict_cnt_r <= conflict_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        conflict_cnt_r <= conflict_cnt_r;
      end
    end
  end

  assign bus.rf_we        = rf_we_r;
  assign bus.rf_waddr     = rf_waddr_r;
  assign bus.rf_wdata     = rf_wdata_r;
  assign bus.pending      = pending_r;
  assign bus.conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table, corner sequences, random vs model.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

`ifdef REGFILE_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_write_arbiter_if bus();
  regfile_write_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int total = 0;
  int bad = 0;

  typedef struct {
    bit r0v; reg_addr_t r0a; reg_data_t r0d;
    bit r1v; reg_addr_t r1a; reg_data_t r1d;
    bit rsvv; reg_addr_t rsva; reg_addr_t rd1; reg_addr_t rd2;
    bit g0; bit g1; bit rsvr; bit stall; bit we;
    reg_addr_t waddr; reg_data_t wdata; reg_mask_t pend; int cnt;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input bit r0v, input reg_addr_t r0a, input reg_data_t r0d,
                        input bit r1v, input reg_addr_t r1a, input reg_data_t r1d,
                        input bit rsvv, input reg_addr_t rsva,
                        input reg_addr_t rd1, input reg_addr_t rd2);
    bus.req0_valid = r0v; bus.req0_addr = r0a; bus.req0_data = r0d;
    bus.req1_valid = r1v; bus.req1_addr = r1a; bus.req1_data = r1d;
    bus.rsv_valid = rsvv; bus.rsv_addr = rsva;
    bus.rd_addr1 = rd1; bus.rd_addr2 = rd2;
  endtask

  task automatic idle(input reg_addr_t rd1, input reg_addr_t rd2);
    set_in(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, rd1, rd2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(3'd0, 3'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model state, expressed as plain arrays and integers.
  bit        m_pend[NUM_REGS];
  int        m_cnt;
  int        m_last_winner;
  bit        m_we;
  reg_addr_t m_waddr;
  reg_data_t m_wdata;

  function automatic reg_mask_t m_pend_vec();
    reg_mask_t v;
    v = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit m_blocks(input reg_addr_t a);
    if (BYP && m_we && (m_waddr == a)) return 1'b0;
    return m_pend[a];
  endfunction

  initial begin
    vt[0]  = '{1'b1, 3'd3, 32'hDEAD_BEEF, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0, 3'd0,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 8'h00, 0};
    vt[1]  = '{1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0, 3'd0,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF, 8'h00, 0};
    vt[2]  = '{1'b1, 3'd0, 32'hACED_CAFE, 1'b1, 3'd7, 32'hFFFF_FFFF, 1'b0, 3'd0, 3'd0, 3'd0,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 8'h00, 0};
    vt[3]  = '{1'b0, 3'd0, 32'd0, 1'b1, 3'd7, 32'hFFFF_FFFF, 1'b0, 3'd0, 3'd0, 3'd0,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'hACED_CAFE, 8'h00, 1};
    vt[4]  = '{1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1, 3'd2, 3'd2, 3'd0,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 32'hFFFF_FFFF, 8'h00, 1};
    vt[5]  = '{1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1, 3'd2, 3'd2, 3'd0,
               1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 8'h04, 1};
    vt[6]  = '{1'b0, 3'd0, 32'd0, 1'b1, 3'd2, 32'h0000_0022, 1'b0, 3'd0, 3'd2, 3'd0,
               1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 8'h04, 1};
    vt[7]  = '{1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd2, 3'd0,
               1'b0, 1'b0, 1'b1, !BYP, 1'b1, 3'd2, 32'h0000_0022, 8'h04, 1};
    vt[8]  = '{1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd2, 3'd0,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 8'h00, 1};
    vt[9]  = '{1'b1, 3'd4, 32'h0000_0044, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0, 3'd0,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 8'h00, 1};
    vt[10] = '{1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1, 3'd4, 3'd0, 3'd4,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 32'h0000_0044, 8'h00, 1};
    vt[11] = '{1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0, 3'd4,
               1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 8'h10, 1};
  end

  initial begin
    #2;
    // Reset held two cycles with a request present.
    rst_n = 1'b0;
    set_in(1'b1, 3'd1, 32'h0000_0011, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0, 3'd0);
    tick();
    tick();
    @(negedge clk);
    chk("rst_we", bus.rf_we, 1'b0);
    chk("rst_pending", bus.pending, 8'h00);
    chk("rst_cnt", bus.conflict_cnt, 16'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready0", bus.req0_ready, 1'b1);
    tick();
    idle(3'd0, 3'd0);
    @(negedge clk);
    chk("rel_we", bus.rf_we, 1'b1);
    chk("rel_waddr", bus.rf_waddr, 3'd1);
    chk("rel_wdata", bus.rf_wdata, 32'h0000_0011);
    tick();

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      set_in(vt[i].r0v, vt[i].r0a, vt[i].r0d, vt[i].r1v, vt[i].r1a, vt[i].r1d,
             vt[i].rsvv, vt[i].rsva, vt[i].rd1, vt[i].rd2);
      @(negedge clk);
      chk($sformatf("v%0d_ready0", i), bus.req0_ready, vt[i].g0);
      chk($sformatf("v%0d_ready1", i), bus.req1_ready, vt[i].g1);
      chk($sformatf("v%0d_rsv_ready", i), bus.rsv_ready, vt[i].rsvr);
      chk($sformatf("v%0d_rd_stall", i), bus.rd_stall, vt[i].stall);
      chk($sformatf("v%0d_rf_we", i), bus.rf_we, vt[i].we);
      if (vt[i].we) begin
        chk($sformatf("v%0d_rf_waddr", i), bus.rf_waddr, vt[i].waddr);
        chk($sformatf("v%0d_rf_wdata", i), bus.rf_wdata, vt[i].wdata);
      end
      chk($sformatf("v%0d_pending", i), bus.pending, vt[i].pend);
      chk($sformatf("v%0d_cnt", i), bus.conflict_cnt, vt[i].cnt);
      tick();
    end

    // Fairness: both ports valid for six cycles from reset.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 3'd1, 32'h0000_00A0, 1'b1, 3'd6, 32'h0000_00B1, 1'b0, 3'd0, 3'd0, 3'd0);
      @(negedge clk);
      chk($sformatf("fair%0d_gnt0", i), bus.req0_ready, (i % 2) == 0);
      chk($sformatf("fair%0d_gnt1", i), bus.req1_ready, (i % 2) == 1);
      if (i > 0) begin
        chk($sformatf("fair%0d_we", i), bus.rf_we, 1'b1);
        chk($sformatf("fair%0d_waddr", i), bus.rf_waddr, ((i % 2) == 1) ? 3'd1 : 3'd6);
      end
      tick();
    end
    idle(3'd0, 3'd0);
    @(negedge clk);
    chk("fair_cnt", bus.conflict_cnt, 16'd6);
    chk("fair_last_we", bus.rf_we, 1'b1);
    chk("fair_last_waddr", bus.rf_waddr, 3'd6);
    tick();

    // Write-port cycle on a pending register.
    set_in(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1, 3'd5, 3'd0, 3'd0);
    tick();
    set_in(1'b1, 3'd5, 32'h1234_5678, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 3'd0, 3'd5);
    @(negedge clk);
    chk("byp_pre_stall", bus.rd_stall, 1'b1);
    tick();
    idle(3'd0, 3'd5);
    @(negedge clk);
    chk("byp_we", bus.rf_we, 1'b1);
    chk("byp_stall", bus.rd_stall, !BYP);
`ifdef REGFILE_ARB_BYPASS_EN
    chk("byp_hit2", bus.byp_hit2, 1'b1);
    chk("byp_hit1", bus.byp_hit1, 1'b0);
    chk("byp_data", bus.byp_data, 32'h1234_5678);
`endif
    tick();
    @(negedge clk);
    chk("byp_post_stall", bus.rd_stall, 1'b0);
    chk("byp_post_pending", bus.pending, 8'h00);
    tick();

    // Randomized traffic against the reference model.
    do_reset();
    run_random(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic run_random(input int cycles);
    bit r0v, r1v, hold0, hold1, rsvv, eg0, eg1, ersvr, both;
    reg_addr_t r0a, r1a, rsva, rd1, rd2;
    reg_data_t r0d, r1d;
    for (int i = 0; i < NUM_REGS; i++) m_pend[i] = 1'b0;
    m_cnt = 0; m_last_winner = 1; m_we = 1'b0; m_waddr = 3'd0; m_wdata = 32'd0;
    hold0 = 1'b0; hold1 = 1'b0;
    r0v = 1'b0; r1v = 1'b0; r0a = 3'd0; r1a = 3'd0; r0d = 32'd0; r1d = 32'd0;
    for (int c = 0; c < cycles; c++) begin
      if (!hold0) begin
        r0v = ($urandom_range(0, 2) != 0); r0a = 3'($urandom_range(0, 7)); r0d = $urandom;
      end
      if (!hold1) begin
        r1v = ($urandom_range(0, 2) != 0); r1a = 3'($urandom_range(0, 7)); r1d = $urandom;
      end
      rsvv = ($urandom_range(0, 1) != 0);
      rsva = 3'($urandom_range(0, 7));
      rd1 = 3'($urandom_range(0, 7));
      rd2 = 3'($urandom_range(0, 7));
      set_in(r0v, r0a, r0d, r1v, r1a, r1d, rsvv, rsva, rd1, rd2);

      both = r0v && r1v;
      eg0 = both ? (m_last_winner == 1) : r0v;
      eg1 = both ? (m_last_winner == 0) : r1v;
      ersvr = !m_pend[rsva];
      @(negedge clk);
      chk("rnd_ready0", bus.req0_ready, eg0);
      chk("rnd_ready1", bus.req1_ready, eg1);
      chk("rnd_rsv_ready", bus.rsv_ready, ersvr);
      chk("rnd_rd_stall", bus.rd_stall, m_blocks(rd1) | m_blocks(rd2));
      chk("rnd_rf_we", bus.rf_we, m_we);
      if (m_we) begin
        chk("rnd_rf_waddr", bus.rf_waddr, m_waddr);
        chk("rnd_rf_wdata", bus.rf_wdata, m_wdata);
      end
      chk("rnd_pending", bus.pending, m_pend_vec());
      chk("rnd_cnt", bus.conflict_cnt, m_cnt);
`ifdef REGFILE_ARB_BYPASS_EN
      chk("rnd_byp_hit1", bus.byp_hit1, m_we && (m_waddr == rd1));
      chk("rnd_byp_hit2", bus.byp_hit2, m_we && (m_waddr == rd2));
      if (m_we) chk("rnd_byp_data", bus.byp_data, m_wdata);
`endif
      // Advance the model to the state after this edge.
      if (m_we) m_pend[m_waddr] = 1'b0;
      if (rsvv && ersvr) m_pend[rsva] = 1'b1;
      if (both && m_cnt < 65535) m_cnt++;
      if (both) m_last_winner = eg0 ? 0 : 1;
      m_we = eg0 || eg1;
      if (eg0) begin
        m_waddr = r0a; m_wdata = r0d;
      end else if (eg1) begin
        m_waddr = r1a; m_wdata = r1d;
      end
      hold0 = r0v && !eg0;
      hold1 = r1v && !eg1;
      tick();
    end
  endtask

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 8x32 register file (registersArray) between two writeback requesters: port 0 = ALU, port 1 = load unit.
- Keeps a per-register pending scoreboard so read-port consumers can stall on outstanding writes.
- Sits between the execute/memory stages and the register file's write inputs (address, data, write enable).

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 3, register address width.
- NUM_REGS, 8, register count; must equal 2**ADDR_W.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req0_valid / req1_valid  in  1  writeback request valid.
- req0_ready / req1_ready  out  1  request granted this cycle (combinational).
- req0_addr / req1_addr  in  ADDR_W  destination register.
- req0_data / req1_data  in  DATA_W  write data.
- rsv_valid  in  1  reserve destination register (issue stage).
- rsv_addr  in  ADDR_W  register to reserve.
- rsv_ready  out  1  reservation accepted.
- rd_addr1 / rd_addr2  in  ADDR_W  register file read addresses being used.
- rd_stall  out  1  a read address hits a pending register.
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  ADDR_W  register file write address (registered).
- rf_wdata  out  DATA_W  register file write data (registered).
- pending  out  NUM_REGS  scoreboard bit vector.
- conflict_cnt  out  CNT_W  cycles in which both requesters were valid.

Behaviour:
- Reset (rst_n low at an edge): rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, conflict_cnt=0, rr_last=1, so port 0 wins the first conflict. Reset mid-transfer drops the in-flight write.
- Grant, combinational:
  - Only one valid: that port is granted.
  - Both valid: the port other than rr_last is granted.
  - Neither valid: no grant.
  - reqX_ready = granted X. A request is accepted when valid && ready.
- Latency: an accepted request appears on rf_we/rf_waddr/rf_wdata in the next cycle. rf_we stays high for exactly one cycle per accepted request. Back-to-back accepts give rf_we high on consecutive cycles.
- rr_last updates to the granted port only on cycles where both requesters are valid.
- Loser handshake: the losing requester must hold valid, addr and data stable until it is granted.
- Scoreboard:
  - rsv_ready = ~pending[rsv_addr].
  - rsv_valid && rsv_ready sets pending[rsv_addr] at the edge.
  - pending[rf_waddr] clears at the edge where rf_we=1, which is the edge the register file commits the write.
  - Same edge, same address, set and clear both active: set wins, giving a new reservation.
  - A write to a non-pending register is legal and leaves the scoreboard unchanged.
- rd_stall = pending[rd_addr1] | pending[rd_addr2]. Combinational, no registered delay.
- conflict_cnt increments on every cycle with req0_valid && req1_valid and saturates at all-ones.
- Same-address writes from both ports: serviced in grant order. The later one wins in the register file.

Optional Feature:
- REGFILE_ARB_BYPASS_EN
- Defined:
  - Extra outputs byp_hit1/byp_hit2 (1 bit) and byp_data (DATA_W).
  - byp_hitN = rf_we && rf_waddr==rd_addrN, and byp_data = rf_wdata.
  - In the cycle the write is on the port, rd_stall ignores a matching pending bit for that address, so consumers take byp_data.
- Undefined: bypass ports absent. rd_stall asserts for a pending address until the edge after rf_we.

Decomposition:
- Shared package regfile_pkg:
  - Constants DATA_W=32, ADDR_W=3, NUM_REGS=8.
  - typedef reg_addr_t, reg_data_t.
  - typedef wb_req_t, a struct of valid/addr/data.
- Sub-module rr_arbiter2: 2-way round-robin grant plus the rr_last register. The scoreboard and output registers stay in the top.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles while req0_valid=1 -> rf_we=0, pending=8'h00, conflict_cnt=0. First accept occurs on the first cycle after release.
- Single port: req0 addr=3'b011, data=32'hDEAD_BEEF for 1 cycle -> next cycle rf_we=1, rf_waddr=3, rf_wdata=DEADBEEF, then rf_we=0.
- Conflict: req0 (addr 0, 32'hACED_CAFE) and req1 (addr 7, 32'hFFFF_FFFF) held valid together -> port 0 granted first, port 1 next cycle, conflict_cnt=1.
- Fairness: both ports continuously valid for 6 cycles -> grants alternate 0,1,0,1,0,1 and conflict_cnt=6.
- Scoreboard: reserve reg 2, then rd_addr1=2 -> rd_stall=1. A second reserve of reg 2 sees rsv_ready=0. After a req1 write to reg 2, pending[2] clears at the edge where rf_we=1, and rd_stall=0 the following cycle.
- Bypass (macro defined): reserve reg 5, write 32'h1234_5678 to reg 5 with rd_addr2=5 -> in the rf_we cycle byp_hit2=1, byp_data=12345678, rd_stall=0. Without the macro, rd_stall=1 in that cycle.
